lsu_pipe: RTL

- Pipelined load/store unit between the core execute stage and the data-memory port.
- Accepts load/store requests on a valid/ready handshake and issues them to memory through a registered request stage.
- Tracks up to Depth in-flight accesses in an in-order pending FIFO.
- Returns tagged, aligned and sign/zero-extended responses in order; flags misaligned/illegal accesses as error responses without touching memory.

---
 rtl/lsu_pipe.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_pipe.sv
// Pipelined load/store unit: registered memory request stage plus an in-order
// pending FIFO that returns tagged, aligned and extended responses.
module lsu_pipe #(
   parameter int Xlen  = 32,
   parameter int Depth = 2,
   parameter int TagW  = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [Xlen-1:0]   req_addr_i,
   input  logic [Xlen-1:0]   req_wdata_i,
   input  logic [2:0]        req_funct3_i,
   input  logic [TagW-1:0]   req_tag_i,
   output logic              rsp_valid_o,
   output logic [Xlen-1:0]   rsp_rdata_o,
   output logic [TagW-1:0]   rsp_tag_o,
   output logic              rsp_err_o,
   output logic              busy_o,
   output logic              mem_valid_o,
   input  logic              mem_ready_i,
   output logic              mem_we_o,
   output logic [Xlen-1:0]   mem_addr_o,
   output logic [Xlen-1:0]   mem_wdata_o,
   output logic [Xlen/8-1:0] mem_wmask_o,
   input  logic [Xlen-1:0]   mem_rdata_i,
   input  logic              mem_rvalid_i
);
   localparam int NB   = Xlen / 8;
   localparam int OffW = $clog2(NB);
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   logic [OffW-1:0] w_off;
   logic [1:0]      w_size;
   logic            w_err;
   logic [NB-1:0]   w_mask;
   logic [Xlen-1:0] w_wdata;
   logic            w_accept;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic            w_head_err;
   logic [Xlen-1:0] w_shift;
   logic [Xlen-1:0] w_rdata;

   logic            r_mem_valid;
   logic            r_mem_we;
   logic [Xlen-1:0] r_mem_addr;
   logic [Xlen-1:0] r_mem_wdata;
   logic [NB-1:0]   r_mem_wmask;

   logic [PtrW-1:0] r_wr_ptr;
   logic [PtrW-1:0] r_rd_ptr;
   logic [CntW-1:0] r_count;
   logic [TagW-1:0] r_tag_q [Depth];
   logic [2:0]      r_f3_q  [Depth];
   logic [OffW-1:0] r_off_q [Depth];
   logic            r_we_q  [Depth];
   logic            r_err_q [Depth];

   assign w_off  = req_addr_i[OffW-1:0];
   assign w_size = req_funct3_i[1:0];

   // Errored requests still take a FIFO slot so responses stay in order.
   always_comb begin
      w_err = 1'b0;
      if (req_funct3_i == 3'd7) w_err = 1'b1;
      if (Xlen == 32 && (req_funct3_i == 3'd3 || req_funct3_i == 3'd6)) w_err = 1'b1;
      if (req_we_i && req_funct3_i[2]) w_err = 1'b1;
      case (w_size)
         2'd1:    if (w_off[0]) w_err = 1'b1;
         2'd2:    if (w_off[1:0] != 2'b00) w_err = 1'b1;
         2'd3:    if (w_off != '0) w_err = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      w_mask = '0;
      if (req_we_i) begin
         case (w_size)
            2'd0:    w_mask = NB'(1) << w_off;
            2'd1:    w_mask = NB'(3) << w_off;
            2'd2:    w_mask = NB'(15) << w_off;
            default: w_mask = '1;
         endcase
      end
   end

   assign w_wdata = req_wdata_i << {w_off, 3'b000};

   assign w_full      = (r_count == CntW'(Depth));
   assign w_empty     = (r_count == '0);
   assign req_ready_o = !rst_i && !w_full && (!r_mem_valid || mem_ready_i);
   assign w_accept    = req_valid_i && req_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_mem_valid <= 1'b0;
      end else if (w_accept && !w_err) begin
         r_mem_valid <= 1'b1;
      end else if (mem_ready_i) begin
         r_mem_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_accept && !w_err) begin
         r_mem_we    <= req_we_i;
         r_mem_addr  <= {req_addr_i[Xlen-1:OffW], {OffW{1'b0}}};
         r_mem_wdata <= w_wdata;
         r_mem_wmask <= w_mask;
      end
   end

   function automatic logic [PtrW-1:0] f_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_accept) r_wr_ptr <= f_inc(r_wr_ptr);
         if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_tag_q[r_wr_ptr] <= req_tag_i;
         r_f3_q[r_wr_ptr]  <= req_funct3_i;
         r_off_q[r_wr_ptr] <= w_off;
         r_we_q[r_wr_ptr]  <= req_we_i;
         r_err_q[r_wr_ptr] <= w_err;
      end
   end

   assign w_head_err = r_err_q[r_rd_ptr];
   assign w_pop      = !w_empty && (w_head_err || mem_rvalid_i);
   assign w_shift    = mem_rdata_i >> {r_off_q[r_rd_ptr], 3'b000};

   always_comb begin
      w_rdata = '0;
      if (!w_head_err && !r_we_q[r_rd_ptr]) begin
         case (r_f3_q[r_rd_ptr][1:0])
            2'd0: begin
               if (r_f3_q[r_rd_ptr][2]) w_rdata = Xlen'(w_shift[7:0]);
               else                     w_rdata = Xlen'($signed(w_shift[7:0]));
            end
            2'd1: begin
               if (r_f3_q[r_rd_ptr][2]) w_rdata = Xlen'(w_shift[15:0]);
               else                     w_rdata = Xlen'($signed(w_shift[15:0]));
            end
            2'd2: begin
               if (r_f3_q[r_rd_ptr][2]) w_rdata = Xlen'(w_shift[31:0]);
               else                     w_rdata = Xlen'($signed(w_shift[31:0]));
            end
            default: w_rdata = w_shift;
         endcase
      end
   end

   assign rsp_valid_o = w_pop;
   assign rsp_rdata_o = w_rdata;
   assign rsp_tag_o   = r_tag_q[r_rd_ptr];
   assign rsp_err_o   = !w_empty && w_head_err;
   assign busy_o      = r_mem_valid || !w_empty;

   assign mem_valid_o = r_mem_valid;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign mem_wmask_o = r_mem_wmask;

   // An errored head never went to memory, so a read-valid then is a protocol error.
   a_no_rvalid_on_err : assert property (@(posedge clk_i) disable iff (rst_i)
      !(mem_rvalid_i && !w_empty && w_head_err));

endmodule
